// File: rtl/phase_demod.sv
// Carrier phase removal: result = rx * conj(ph), Q1.11 phasor, with ap_* block handshake.
// state | meaning
// IDLE  | waiting for ap_start; inputs captured on accept
// CAP   | four cross products registered
// MUL   | sums formed, rounded/saturated into result registers
// OUT   | ap_done and both vld strobes high for one cycle
module phase_demod #(
  parameter int W    = 12,
  parameter int FRAC = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ap_start,
  output logic         ap_done,
  output logic         ap_idle,
  output logic         ap_ready,
  input  logic [W-1:0] rx_in_real,
  input  logic [W-1:0] rx_in_imag,
  input  logic [W-1:0] ph_in_real,
  input  logic [W-1:0] ph_in_imag,
  output logic [W-1:0] result_real,
  output logic [W-1:0] result_imag,
  output logic         result_real_vld,
  output logic         result_imag_vld
);

  localparam int PW = 2 * W;
  localparam int SW = 2 * W + 1;
  localparam logic signed [SW:0] RND_HALF = (SW + 1)'(1) <<< (FRAC - 1);
  localparam logic signed [SW:0] SAT_MAX  = (SW + 1)'((1 << (W - 1)) - 1);
  localparam logic signed [SW:0] SAT_MIN  = -SAT_MAX;

  typedef enum logic [1:0] {IDLE, CAP, MUL, OUT} state_t;

  state_t               state_q;
  logic signed [W-1:0]  rx_r_q, rx_i_q, ph_r_q, ph_i_q;
  logic signed [PW-1:0] p_rr_q, p_ii_q, p_ir_q, p_ri_q;
  logic        [W-1:0]  res_re_q, res_im_q;
  logic                 done_q;

  logic signed [SW-1:0] sum_re_d, sum_im_d;
  logic        [W-1:0]  res_re_d, res_im_d;

  // Round half up, then clamp symmetrically so -2^(W-1) never appears.
  function automatic logic [W-1:0] round_sat(input logic signed [SW-1:0] s);
    logic signed [SW:0] r;
    logic signed [SW:0] q;
    r = $signed({s[SW-1], s}) + RND_HALF;
    q = r >>> FRAC;
    if (q > SAT_MAX)      q = SAT_MAX;
    else if (q < SAT_MIN) q = SAT_MIN;
    return q[W-1:0];
  endfunction

  always_comb begin
    sum_re_d = $signed({p_rr_q[PW-1], p_rr_q}) + $signed({p_ii_q[PW-1], p_ii_q});
    sum_im_d = $signed({p_ir_q[PW-1], p_ir_q}) - $signed({p_ri_q[PW-1], p_ri_q});
    res_re_d = round_sat(sum_re_d);
    res_im_d = round_sat(sum_im_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rx_r_q   <= '0;
      rx_i_q   <= '0;
      ph_r_q   <= '0;
      ph_i_q   <= '0;
      p_rr_q   <= '0;
      p_ii_q   <= '0;
      p_ir_q   <= '0;
      p_ri_q   <= '0;
      res_re_q <= '0;
      res_im_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ap_start) begin
            rx_r_q  <= $signed(rx_in_real);
            rx_i_q  <= $signed(rx_in_imag);
            ph_r_q  <= $signed(ph_in_real);
            ph_i_q  <= $signed(ph_in_imag);
            state_q <= CAP;
          end
        end
        CAP: begin
          p_rr_q  <= rx_r_q * ph_r_q;
          p_ii_q  <= rx_i_q * ph_i_q;
          p_ir_q  <= rx_i_q * ph_r_q;
          p_ri_q  <= rx_r_q * ph_i_q;
          state_q <= MUL;
        end
        MUL: begin
          // Result lands here so it is already valid while ap_done is high in OUT.
          res_re_q <= res_re_d;
          res_im_q <= res_im_d;
          done_q   <= 1'b1;
          state_q  <= OUT;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ap_ready        = (state_q == IDLE) && ap_start && !reset;
  assign ap_idle         = (state_q == IDLE);
  assign ap_done         = done_q;
  assign result_real_vld = done_q;
  assign result_imag_vld = done_q;
  assign result_real     = res_re_q;
  assign result_imag     = res_im_q;

endmodule

// File: tb/tb_phase_demod.sv
// Scoreboard bench for phase_demod: directed vectors, handshake timing, reset abort, loopback.
`timescale 1ns/1ps
module tb_phase_demod;
  localparam int W = 12;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         ap_start = 1'b0;
  logic         ap_done, ap_idle, ap_ready;
  logic [W-1:0] rx_r = '0, rx_i = '0, ph_r = '0, ph_i = '0;
  logic [W-1:0] res_r, res_i;
  logic         vld_r, vld_i;

  phase_demod #(.W(W), .FRAC(11)) dut (
    .clk(clk), .reset(reset), .ap_start(ap_start),
    .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .rx_in_real(rx_r), .rx_in_imag(rx_i), .ph_in_real(ph_r), .ph_in_imag(ph_i),
    .result_real(res_r), .result_imag(res_i),
    .result_real_vld(vld_r), .result_imag_vld(vld_i)
  );

  always #5 clk = ~clk;

  typedef struct {int re; int im; int tol;} exp_t;
  exp_t sb_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int req, input int tol);
    int d;
    n_checks++;
    d = act - req;
    if (d <= tol && d >= -tol) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (tol %0d) at %0t", name, act, req, tol, $time);
  endtask

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction

  // Reference phase_mod output stage: Q1.11 product, round half up, symmetric clamp.
  function automatic int mod_q(input int x);
    int q;
    q = (x + 1024) >>> 11;
    if (q > 2047) q = 2047;
    if (q < -2047) q = -2047;
    return q;
  endfunction

  // Monitor: every strobe cycle pops one expectation.
  always @(negedge clk) begin
    if (ap_done || vld_r || vld_i) begin
      exp_t e;
      chk("strobes_together", int'({ap_done, vld_r, vld_i}), 7, 0);
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got result (%0d,%0d), expected no ap_done at %0t",
                 $signed(res_r), $signed(res_i), $time);
      end else begin
        e = sb_q.pop_front();
        chk("result_real", int'($signed(res_r)), e.re, e.tol);
        chk("result_imag", int'($signed(res_i)), e.im, e.tol);
      end
    end
  end

  task automatic set_inputs(input int rr, input int ri, input int pr, input int pi);
    rx_r = W'(rr);
    rx_i = W'(ri);
    ph_r = W'(pr);
    ph_i = W'(pi);
  endtask

  // One operation with latency/idle checks; inputs scrambled right after accept.
  task automatic start_op(input int rr, input int ri, input int pr, input int pi,
                          input int er, input int ei);
    logic [3:0] dp, ip;
    exp_t e;
    @(posedge clk); #1;
    set_inputs(rr, ri, pr, pi);
    ap_start = 1'b1;
    e.re = er; e.im = ei; e.tol = 0;
    sb_q.push_back(e);
    @(negedge clk);
    chk("ap_ready_accept", int'(ap_ready), 1, 0);
    @(posedge clk); #1;
    ap_start = 1'b0;
    set_inputs(int'($urandom), int'($urandom), int'($urandom), int'($urandom));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      dp[k] = ap_done;
      ip[k] = ap_idle;
    end
    chk("done_at_n_plus_3", int'(dp), 4, 0);
    chk("idle_at_n_plus_4", int'(ip), 8, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [19:0] rp, dp;
    logic        seen;
    exp_t        e;
    int          bb_r, bb_i, pr, pi, rxr, rxi;
    real         g;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("reset_state", int'({ap_idle, ap_done, vld_r, vld_i, res_r, res_i}), 1 << 27, 0);
    end

    start_op( 2047,     0,  2047,     0,  2046,    0);
    start_op(-2048, -2048, -2048, -2048,  2047,    0);
    start_op(-2048, -2048,  2047,  2047, -2047,    0);
    start_op(    0,  1024,     0,  2047,  1024,    0);
    start_op( -300,   700,  1448,  1448,   283,  707);
    start_op(    1,     0,  1024,     0,     1,    0);
    start_op(   -1,    -3,  1024,     0,     0,   -1);

    // ap_start held for 16 cycles: accepts every 4th cycle.
    @(posedge clk); #1;
    set_inputs(1000, -500, 2047, 0);
    ap_start = 1'b1;
    e.re = 1000; e.im = -500; e.tol = 0;
    for (int k = 0; k < 4; k++) sb_q.push_back(e);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      rp[k] = ap_ready;
      dp[k] = ap_done;
      if (k == 15) begin
        @(posedge clk); #1;
        ap_start = 1'b0;
      end
    end
    chk("held_start_ready", int'(rp), 'h01111, 0);
    chk("held_start_done", int'(dp), 'h08888, 0);

    // Reset in MUL discards the operation.
    @(posedge clk); #1;
    set_inputs(500, 500, 2047, 0);
    ap_start = 1'b1;
    @(negedge clk);
    chk("abort_accept", int'(ap_ready), 1, 0);
    @(posedge clk); #1 ap_start = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_state", int'({ap_done, ap_idle, res_r, res_i}), 1 << 24, 0);
    start_op(-300, 700, 1448, 1448, 283, 707);

    // Reset and start together: reset wins.
    @(posedge clk); #1;
    reset = 1'b1;
    ap_start = 1'b1;
    @(negedge clk);
    chk("reset_beats_start", int'(ap_ready), 0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    ap_start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      seen = seen | ap_done;
    end
    chk("no_done_after_reset_start", int'(seen), 0, 0);

    // Loopback: phase_mod output fed back with the same phasor, one start every 4 cycles.
    // The Q1.11 phasor magnitude is slightly below 1, so the loop gain |ph|^2/2^22 is applied.
    for (int i = 0; i < 1000; i++) begin
      bb_r = rnd(2047.0 * $cos(-0.03 * i));
      bb_i = rnd(2047.0 * $sin(-0.03 * i));
      pr   = rnd(2047.0 * $cos(0.01 * i));
      pi   = rnd(2047.0 * $sin(0.01 * i));
      rxr  = mod_q(bb_r * pr - bb_i * pi);
      rxi  = mod_q(bb_r * pi + bb_i * pr);
      g    = real'(pr * pr + pi * pi) / 4194304.0;
      e.re = rnd(real'(bb_r) * g);
      e.im = rnd(real'(bb_i) * g);
      e.tol = 3;
      @(posedge clk); #1;
      set_inputs(rxr, rxi, pr, pi);
      ap_start = 1'b1;
      sb_q.push_back(e);
      @(negedge clk);
      chk("loop_ready", int'(ap_ready), 1, 0);
      repeat (3) @(posedge clk);
    end
    @(posedge clk); #1 ap_start = 1'b0;
    repeat (8) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/phase_demod.md
Name: phase_demod

Overview:
- Hand-written RTL counterpart to the HLS phase modulator.
- Removes a carrier phase by multiplying the received complex sample by the conjugate of the phase phasor: out = rx * conj(ph).
- Exposes the same block-level handshake as the HLS core (ap_start/ap_done/ap_idle/ap_ready) and per-output ap_vld strobes, so the existing start pulse generator and output latch logic drive it unchanged.
- Sits directly after phase_mod in the loopback datapath.

Parameters:
- W, 12, sample width; signed two's complement, all I/O.
- FRAC, 11, fractional bits of the phasor (Q1.11); product scaling shift.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ap_start  in  1  request one operation; sampled only in IDLE
- ap_done  out  1  one-cycle pulse when result is valid
- ap_idle  out  1  high while in IDLE
- ap_ready  out  1  one-cycle pulse when inputs are captured
- rx_in_real  in  W  received sample, real
- rx_in_imag  in  W  received sample, imag
- ph_in_real  in  W  phasor, real
- ph_in_imag  in  W  phasor, imag
- result_real  out  W  demodulated real
- result_imag  out  W  demodulated imag
- result_real_vld  out  1  one-cycle strobe, result_real updated
- result_imag_vld  out  1  one-cycle strobe, result_imag updated

Behaviour:
- Clock clk; reset is synchronous and active-high, named reset.
- Reset: state=IDLE; result_real=result_imag=0; ap_done=0; both vld=0; ap_idle=1; internal pipeline registers=0.
- FSM states, one cycle each outside IDLE: IDLE -> CAP -> MUL -> OUT -> IDLE.
- IDLE: ap_idle=1. On ap_start=1 in cycle N:
  - ap_ready=1 (combinational, state==IDLE && ap_start).
  - All four inputs registered at the end of cycle N.
  - Next state CAP.
- CAP (N+1): four signed WxW products registered (2W bits each).
- MUL (N+2): sums registered (2W+1 bits).
  - sum_re = rx_r*ph_r + rx_i*ph_i
  - sum_im = rx_i*ph_r - rx_r*ph_i
- OUT (N+3):
  - result_* registered = sat(round(sum)).
  - ap_done=1, result_real_vld=1, result_imag_vld=1 for this single cycle.
  - Next state IDLE.
- Latency: ap_start accepted in cycle N -> ap_done/vld high in cycle N+3, result registers already holding the new value. Initiation interval 4 cycles.
- Rounding: add 2^(FRAC-1), then arithmetic shift right by FRAC (round half up toward +inf).
- Saturation: symmetric clamp to [-(2^(W-1)-1), +(2^(W-1)-1)] = [-2047, +2047]; -2048 is never output.
- result_* hold their value between operations; they change only in OUT or on reset.
- ap_start while not IDLE: ignored and not queued. ap_start held high continuously gives back-to-back operations, with ap_ready at N, N+4, N+8, ...
- ap_idle=0 in CAP/MUL/OUT; ap_ready=0 outside IDLE.
- Inputs need be stable only in the accept cycle; later changes do not affect the result in flight.
- Reset asserted in any state: next cycle IDLE with all outputs at reset values; the in-flight operation is discarded and produces no ap_done.
- Reset and ap_start in the same cycle: reset wins, no accept, ap_ready=0.

Test Plan:
- Reset release, no start -> ap_idle=1, ap_done=0, vld=0, result=(0,0) for 20 cycles.
- rx=(2047,0), ph=(2047,0), start pulse at N -> ap_ready at N; ap_done and both vld at N+3 only; result=(2046,0); ap_idle=1 at N+4.
- rx=(-2048,-2048), ph=(-2048,-2048) -> sum_re=8388608, clamps to +2047; imag=0. Then rx=(-2048,-2048), ph=(2047,2047) -> real clamps to -2047; imag=0.
- ap_start held high for 16 cycles from N -> ap_ready at N, N+4, N+8, N+12; ap_done at N+3, N+7, N+11, N+15; no other pulses.
- Start at N, reset asserted at N+2 for 1 cycle -> no ap_done at N+3; result=(0,0); ap_idle=1 at N+3; next start accepted normally.
- Loopback: phase_mod output fed as rx with the same ph (A=2047, ph step +0.01 rad, bb step -0.03 rad, start every 4 cycles) -> result within ±3 LSB of the bb input for 1000 samples.
